// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ev22_pkg
//  Brief    : Shared types and default constants for the EV22 memory /
//             write-back stage.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package ev22_pkg;

    localparam int EV22_DATA_W   = 16;
    localparam int EV22_SEL_W    = 6;
    localparam int EV22_W_REG    = 34;
    localparam int EV22_NULL_REG = 35;

    // Stage controller states; explicit encoding keeps reset value obvious
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage_if
//  Brief    : Memory port of the EV22 memory/write-back stage (req/ack
//             handshake with wait-state support).
//  Revision : 1.0 - initial parametrised release
// ============================================================================
interface mem_wb_stage_if
    import ev22_pkg::*;
#(
    parameter int DATA_W = EV22_DATA_W
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // The stage issues requests; the memory answers them
    modport master (
        output mem_req,
        output mem_we,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : mem_timeout_cnt
//  Brief    : Wait-cycle counter with clear/enable; flags the last allowed
//             wait cycle. TIMEOUT = 0 disables the terminal flag.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module mem_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      terminal
);
    localparam int c_CLOG  = $clog2(TIMEOUT + 1);
    localparam int c_CNT_W = (c_CLOG < 1) ? 1 : c_CLOG;

    logic [c_CNT_W-1:0] r_count;

    // Count wait cycles; clear has priority so a fresh transaction starts at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        if (TIMEOUT != 0) begin : g_timeout
            assign terminal = (r_count == c_CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign terminal = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Brief    : EV22 memory / write-back stage. Routes ALU results to the
//             register file, performs MR/MW through a req/ack memory port,
//             stalls upstream while busy and aborts hung transactions.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module mem_wb_stage
    import ev22_pkg::*;
#(
    parameter int DATA_W   = EV22_DATA_W,
    parameter int SEL_W    = EV22_SEL_W,
    parameter int W_REG    = EV22_W_REG,
    parameter int NULL_REG = EV22_NULL_REG,
    parameter int TIMEOUT  = 15
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              in_valid,
    input  wire logic              mr,
    input  wire logic              mw,
    input  wire logic [DATA_W-1:0] w_in,
    input  wire logic [DATA_W-1:0] data_c,
    input  wire logic [SEL_W-1:0]  sel_c,
    input  wire logic              err_clr,
    mem_wb_stage_if.master         mem,
    output logic                   stall,
    output logic [DATA_W-1:0]      data,
    output logic [SEL_W-1:0]       sel_reg,
    output logic                   wb_en,
    output logic                   err
);
    localparam logic [SEL_W-1:0] c_NULL = SEL_W'(NULL_REG);
    localparam logic [SEL_W-1:0] c_W    = SEL_W'(W_REG);

    state_t             r_state;
    state_t             w_next_state;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  r_wdata;
    logic [SEL_W-1:0]   r_sel;
    logic               r_wb_en;
    logic               r_err;
    logic               w_busy;
    logic               w_accept;
    logic               w_term;
    logic               w_timeout;

    assign w_busy    = (r_state != IDLE);
    assign w_accept  = in_valid && (r_state == IDLE);
    // An ack in the terminal cycle completes normally instead of aborting
    assign w_timeout = w_busy && !mem.mem_ack && w_term;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (!w_busy || mem.mem_ack || w_term),
        .en       (w_busy),
        .terminal (w_term)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state: mr wins over mw; ack or timeout both return to IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && mr)      w_next_state = RD_WAIT;
                else if (w_accept && mw) w_next_state = WR_WAIT;
            end
            RD_WAIT, WR_WAIT: begin
                if (mem.mem_ack || w_term) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs follow the state, so reset drops the request at once
    always_comb begin
        stall         = w_busy;
        mem.mem_req   = w_busy;
        mem.mem_we    = (r_state == WR_WAIT);
        mem.mem_wdata = r_wdata;
    end

    // Write-back path, store data and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_wdata <= '0;
            r_sel   <= c_NULL;
            r_wb_en <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sel   <= c_NULL;
            r_wb_en <= 1'b0;
            if (w_accept && !mr && mw) begin
                r_wdata <= w_in;
            end
            if (w_accept && !mr && !mw) begin
                r_sel   <= sel_c;
                r_wb_en <= (sel_c != c_NULL);
                if (sel_c != c_NULL) r_data <= data_c;
            end
            if (r_state == RD_WAIT && mem.mem_ack) begin
                r_data  <= mem.mem_rdata;
                r_sel   <= c_W;
                r_wb_en <= 1'b1;
            end
            if (w_timeout)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign data    = r_data;
    assign sel_reg = r_sel;
    assign wb_en   = r_wb_en;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Brief    : Directed self-checking bench for mem_wb_stage (TIMEOUT = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        mr;
    logic        mw;
    logic [15:0] w_in;
    logic [15:0] data_c;
    logic [5:0]  sel_c;
    logic        err_clr;
    logic        stall;
    logic [15:0] data;
    logic [5:0]  sel_reg;
    logic        wb_en;
    logic        err;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    mem_wb_stage_if #(.DATA_W(16)) mif ();

    mem_wb_stage #(
        .DATA_W   (16),
        .SEL_W    (6),
        .W_REG    (34),
        .NULL_REG (35),
        .TIMEOUT  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .mr       (mr),
        .mw       (mw),
        .w_in     (w_in),
        .data_c   (data_c),
        .sel_c    (sel_c),
        .err_clr  (err_clr),
        .mem      (mif),
        .stall    (stall),
        .data     (data),
        .sel_reg  (sel_reg),
        .wb_en    (wb_en),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return on the falling edge to sample and drive
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; mr = 0; mw = 0; w_in = '0; data_c = '0;
        sel_c = 6'd35; err_clr = 0; mif.mem_ack = 0; mif.mem_rdata = '0;
        step();
        check("rst_stall",   {31'd0, stall}, 32'd0);
        check("rst_req",     {31'd0, mif.mem_req}, 32'd0);
        check("rst_we",      {31'd0, mif.mem_we}, 32'd0);
        check("rst_wdata",   {16'd0, mif.mem_wdata}, 32'h0);
        check("rst_data",    {16'd0, data}, 32'h0);
        check("rst_sel",     {26'd0, sel_reg}, 32'd35);
        check("rst_wb",      {31'd0, wb_en}, 32'd0);
        check("rst_err",     {31'd0, err}, 32'd0);
        rst = 1'b0;
        step();

        // ALU op to r5, then ALU op to the null register
        in_valid = 1; sel_c = 6'd5; data_c = 16'hABCD;
        step();
        check("alu_sel",   {26'd0, sel_reg}, 32'd5);
        check("alu_data",  {16'd0, data}, 32'hABCD);
        check("alu_wb",    {31'd0, wb_en}, 32'd1);
        check("alu_stall", {31'd0, stall}, 32'd0);
        sel_c = 6'd35; data_c = 16'h1111;
        step();
        check("alu_null_wb",   {31'd0, wb_en}, 32'd0);
        check("alu_null_data", {16'd0, data}, 32'hABCD);

        // Read with ack on the 3rd request cycle
        in_valid = 1; mr = 1; mif.mem_rdata = 16'h1234;
        step();
        in_valid = 0; mr = 0;
        check("rd_c1_stall", {31'd0, stall}, 32'd1);
        check("rd_c1_req",   {31'd0, mif.mem_req}, 32'd1);
        check("rd_c1_we",    {31'd0, mif.mem_we}, 32'd0);
        check("rd_c1_wb",    {31'd0, wb_en}, 32'd0);
        step();
        check("rd_c2_stall", {31'd0, stall}, 32'd1);
        step();
        check("rd_c3_stall", {31'd0, stall}, 32'd1);
        mif.mem_ack = 1;
        step();
        mif.mem_ack = 1;   // stray ack while idle must be ignored
        check("rd_done_stall", {31'd0, stall}, 32'd0);
        check("rd_done_req",   {31'd0, mif.mem_req}, 32'd0);
        check("rd_done_sel",   {26'd0, sel_reg}, 32'd34);
        check("rd_done_data",  {16'd0, data}, 32'h1234);
        check("rd_done_wb",    {31'd0, wb_en}, 32'd1);
        step();
        mif.mem_ack = 0;
        check("idle_ack_req", {31'd0, mif.mem_req}, 32'd0);
        check("idle_ack_sel", {26'd0, sel_reg}, 32'd35);
        check("idle_ack_wb",  {31'd0, wb_en}, 32'd0);

        // Write with ack in the first request cycle
        in_valid = 1; mw = 1; w_in = 16'h00FF;
        step();
        in_valid = 0; mw = 0; w_in = 16'hAAAA; mif.mem_ack = 1;
        check("wr_req",   {31'd0, mif.mem_req}, 32'd1);
        check("wr_we",    {31'd0, mif.mem_we}, 32'd1);
        check("wr_wdata", {16'd0, mif.mem_wdata}, 32'h00FF);
        check("wr_sel",   {26'd0, sel_reg}, 32'd35);
        step();
        mif.mem_ack = 0;
        check("wr_done_req",   {31'd0, mif.mem_req}, 32'd0);
        check("wr_done_we",    {31'd0, mif.mem_we}, 32'd0);
        check("wr_done_wb",    {31'd0, wb_en}, 32'd0);
        check("wr_done_data",  {16'd0, data}, 32'h1234);
        check("wr_done_wdata", {16'd0, mif.mem_wdata}, 32'h00FF);

        // mr and mw together perform a read
        in_valid = 1; mr = 1; mw = 1; mif.mem_rdata = 16'h5A5A;
        step();
        in_valid = 0; mr = 0; mw = 0;
        check("rw_req", {31'd0, mif.mem_req}, 32'd1);
        check("rw_we",  {31'd0, mif.mem_we}, 32'd0);
        mif.mem_ack = 1;
        step();
        mif.mem_ack = 0;
        check("rw_sel",  {26'd0, sel_reg}, 32'd34);
        check("rw_data", {16'd0, data}, 32'h5A5A);

        // Timeout after four unanswered request cycles
        in_valid = 1; mr = 1;
        step();
        in_valid = 0; mr = 0;
        check("to_c1_req", {31'd0, mif.mem_req}, 32'd1);
        step();
        step();
        step();
        check("to_c4_req", {31'd0, mif.mem_req}, 32'd1);
        check("to_c4_err", {31'd0, err}, 32'd0);
        step();
        check("to_req",   {31'd0, mif.mem_req}, 32'd0);
        check("to_err",   {31'd0, err}, 32'd1);
        check("to_wb",    {31'd0, wb_en}, 32'd0);
        check("to_stall", {31'd0, stall}, 32'd0);
        check("to_data",  {16'd0, data}, 32'h5A5A);
        err_clr = 1;
        step();
        err_clr = 0;
        check("to_clr_err", {31'd0, err}, 32'd0);

        // Ack in the terminal cycle completes normally
        in_valid = 1; mr = 1; mif.mem_rdata = 16'hC3C3;
        step();
        in_valid = 0; mr = 0;
        step();
        step();
        step();
        mif.mem_ack = 1;
        step();
        mif.mem_ack = 0;
        check("late_ack_req",  {31'd0, mif.mem_req}, 32'd0);
        check("late_ack_err",  {31'd0, err}, 32'd0);
        check("late_ack_sel",  {26'd0, sel_reg}, 32'd34);
        check("late_ack_data", {16'd0, data}, 32'hC3C3);

        // Timeout coinciding with err_clr: set wins
        in_valid = 1; mr = 1;
        step();
        in_valid = 0; mr = 0;
        step();
        step();
        step();
        err_clr = 1;
        step();
        check("set_wins_err", {31'd0, err}, 32'd1);
        step();
        err_clr = 0;
        check("clr_after_err", {31'd0, err}, 32'd0);

        // Reset in the 2nd RD_WAIT cycle acts immediately
        in_valid = 1; mr = 1; mif.mem_rdata = 16'h7777;
        step();
        in_valid = 0; mr = 0;
        step();
        rst = 1;
        #1;
        check("arst_req",   {31'd0, mif.mem_req}, 32'd0);
        check("arst_sel",   {26'd0, sel_reg}, 32'd35);
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_data",  {16'd0, data}, 32'h0);
        @(negedge clk);
        rst = 0; mif.mem_ack = 1;
        step();
        mif.mem_ack = 0;
        check("post_rst_req",  {31'd0, mif.mem_req}, 32'd0);
        check("post_rst_sel",  {26'd0, sel_reg}, 32'd35);
        check("post_rst_wb",   {31'd0, wb_en}, 32'd0);
        check("post_rst_data", {16'd0, data}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
